jtvigil_colmix: RTL
===================

JTVIGIL_COLMIX -- requirements
Module: jtvigil_colmix

Interface
REQ-001 The block SHALL have parameter BLANK_BLACK, default 1, meaning RGB outputs are forced to 0 while either blanking delay signal is low.
REQ-002 The block SHALL have these ports, in this order:
- clk, input, 1, sole clock, 48 MHz.
- rst_n, input, 1, synchronous active-low reset.
- pxl_cen, input, 1, pixel clock enable, 6 MHz.
- LHBL, input, 1, horizontal blank, active low.
- LVBL, input, 1, vertical blank, active low.
- scr1_pxl, input, 8, scroll-1 pixel: [3:0] colour (0 is transparent), [7:4] palette.
- scr2_pxl, input, 4, scroll-2 background pixel.
- obj_pxl, input, 8, sprite pixel: [3:0] colour (0 is transparent), [7:4] palette.
- main_addr, input, 10, CPU palette address.
- main_dout, input, 8, CPU write data.
- main_rnw, input, 1, CPU read (1) or write (0).
- pal_cs, input, 1, CPU palette chip select.
- main_din, output, 8, CPU read data.
- gfx_en, input, 4, layer enables: [0] scr1, [1] scr2, [2] obj, [3] unused.
- red, output, 5, red component.
- green, output, 5, green component.
- blue, output, 5, blue component.
- LHBL_dly, output, 1, LHBL aligned to the RGB outputs.
- LVBL_dly, output, 1, LVBL aligned to the RGB outputs.
REQ-003 The block SHALL use one clock (clk) and a synchronous, active-low reset (rst_n); there SHALL be no other clock domains.

Function
REQ-004 The palette SHALL be three arrays (R, G and B), each 256 entries x 5 bits, dual-ported: one CPU port and one video read port.
REQ-005 CPU address decode SHALL be: main_addr[9:8]=0 selects R, 1 selects G, 2 selects B, 3 is unmapped; main_addr[7:0] is the entry.
REQ-006 A CPU write SHALL occur on every clk cycle with pal_cs=1 and main_rnw=0, storing main_dout[4:0]; writes to bank 3 SHALL be ignored.
REQ-007 A CPU read SHALL present {3'b0, entry} on main_din one clk after the cycle with pal_cs=1 and main_rnw=1; bank 3 SHALL read 8'h00.
REQ-008 main_din SHALL hold its last value when pal_cs=0.
REQ-009 Layer gating: a disabled layer (its gfx_en bit is 0) SHALL be treated as transparent; scr2 is transparent only when it is disabled.
REQ-010 Stage 1, on pxl_cen, SHALL register the 8-bit colour index chosen by the first match in this priority order:
- obj opaque: idx = {1'b1, obj_pxl[6:0]};
- else scr1 opaque: idx = {2'b00, scr1_pxl[5:0]};
- else scr2 enabled: idx = {4'b0100, scr2_pxl};
- else: none (black flag set).
REQ-011 Stage 2, on pxl_cen, SHALL read R[idx], G[idx] and B[idx] and register them into red, green and blue; if the black flag is set, the outputs SHALL be 0.
REQ-012 Total latency from pixel inputs to RGB outputs SHALL be exactly 2 pxl_cen events.
REQ-013 LHBL_dly and LVBL_dly SHALL be LHBL and LVBL delayed by exactly 2 pxl_cen events through a shift register advanced only on pxl_cen.
REQ-014 With BLANK_BLACK=1, RGB SHALL be 0 on any pxl_cen where the stage-1 blanking sample (LHBL & LVBL) is 0, so blanking stays aligned with the pixel data.
REQ-015 A CPU write and a video read of the same entry in the same clk cycle SHALL give the video port the old value (read-before-write); the new value SHALL be visible from the next read.
REQ-016 Outputs SHALL not change between pxl_cen events.
REQ-017 CPU access SHALL be serviced on any clk cycle, independent of pxl_cen and blanking.

Reset
REQ-018 While rst_n=0, at each clk edge: red, green, blue, main_din and the stage-1 index SHALL be set to 0, LHBL_dly and LVBL_dly SHALL be set to 0, and the black flag SHALL be set to 1.
REQ-019 Palette RAM contents SHALL NOT be cleared by reset.
REQ-020 A reset asserted mid-line SHALL abort the pipeline; the first valid RGB SHALL appear on the 2nd pxl_cen after rst_n returns to 1.
REQ-021 CPU writes presented while rst_n=0 SHALL be ignored.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write R[0x85]=0x1F, G[0x85]=0x0A, B[0x85]=0x03; drive obj_pxl=0x05, scr1_pxl=0x13, LHBL=LVBL=1 -> after 2 pxl_cen, RGB = (1F, 0A, 03).
- obj_pxl=0x00, scr1_pxl=0x00, scr2_pxl=0x7 -> idx 0x47 is used; then gfx_en=4'b0000 -> RGB = 0.
- Write 0x12 to address 0x1A0, read back -> main_din = 0x12 one clk later; write to 0x3A0 then read it -> main_din = 0x00.
- Drop LHBL for 4 pxl_cen -> LHBL_dly low exactly 2 pxl_cen later for 4 pxl_cen, with RGB = 0 throughout.
- CPU write of 0x1F to the entry being displayed, in the same clk as the video read -> the current pixel shows the old value, the next pixel shows 0x1F.
- Assert rst_n=0 mid-line -> all outputs are 0 on the next clk, palette contents are kept, and valid RGB returns 2 pxl_cen after release.

Source files
------------

// File: rtl/jtvigil_colmix.sv
// jtvigil_colmix: CPU-writable RGB palette and two-stage layer mixer with
// blanking delayed to stay aligned with the pixel data.
module jtvigil_colmix #(
  parameter bit BLANK_BLACK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [7:0] scr1_pxl,
  input  logic [3:0] scr2_pxl,
  input  logic [7:0] obj_pxl,
  input  logic [9:0] main_addr,
  input  logic [7:0] main_dout,
  input  logic       main_rnw,
  input  logic       pal_cs,
  output logic [7:0] main_din,
  input  logic [3:0] gfx_en,
  output logic [4:0] red,
  output logic [4:0] green,
  output logic [4:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);
  logic [4:0] pal_r [256];
  logic [4:0] pal_g [256];
  logic [4:0] pal_b [256];
  logic [1:0] bank;
  logic [7:0] ent;
  logic       wr;
  logic [4:0] cpu_rd;
  logic       obj_op, scr1_op, nxt_black, black, kill;
  logic [7:0] nxt_idx, idx;
  logic [1:0] hs, vs;
  logic       unused;

  assign bank   = main_addr[9:8];
  assign ent    = main_addr[7:0];
  assign wr     = rst_n && pal_cs && !main_rnw;
  assign unused = ^{gfx_en[3], obj_pxl[7], scr1_pxl[7:6], main_dout[7:5]};

  always_comb begin
    cpu_rd    = bank == 2'd0 ? pal_r[ent] : bank == 2'd1 ? pal_g[ent] : bank == 2'd2 ? pal_b[ent] : 5'd0;
    obj_op    = gfx_en[2] && obj_pxl[3:0] != 4'd0;
    scr1_op   = gfx_en[0] && scr1_pxl[3:0] != 4'd0;
    nxt_idx   = obj_op ? {1'b1, obj_pxl[6:0]} : scr1_op ? {2'b00, scr1_pxl[5:0]} : {4'b0100, scr2_pxl};
    nxt_black = !(obj_op || scr1_op || gfx_en[1]);
    kill      = black || (BLANK_BLACK && !(hs[0] && vs[0]));
  end

  // Palette is never reset; the video read below sees the pre-write value on a same-cycle write
  always_ff @(posedge clk) begin
    if (wr && bank == 2'd0) pal_r[ent] <= main_dout[4:0];
    if (wr && bank == 2'd1) pal_g[ent] <= main_dout[4:0];
    if (wr && bank == 2'd2) pal_b[ent] <= main_dout[4:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) main_din <= 8'd0;
    else if (pal_cs && main_rnw) main_din <= {3'b0, cpu_rd};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= 8'd0;
      black <= 1'b1;
      hs    <= 2'b00;
      vs    <= 2'b00;
      red   <= 5'd0;
      green <= 5'd0;
      blue  <= 5'd0;
    end else if (pxl_cen) begin
      idx   <= nxt_idx;
      black <= nxt_black;
      hs    <= {hs[0], LHBL};
      vs    <= {vs[0], LVBL};
      red   <= kill ? 5'd0 : pal_r[idx];
      green <= kill ? 5'd0 : pal_g[idx];
      blue  <= kill ? 5'd0 : pal_b[idx];
    end
  end

  assign LHBL_dly = hs[1];
  assign LVBL_dly = vs[1];
endmodule
